// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// Shares the single register-file write port (WE3/AD3/WD3) between two
// writeback requesters: A (main pipeline) and B (long-latency unit).
// A has fixed priority. A starvation guard forces one B slot after B has
// been valid-and-denied for STARVE_LIMIT consecutive cycles.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   a_valid/a_ready/a_rd/a_data   requester A handshake and payload
//   b_valid/b_ready/b_rd/b_data   requester B handshake and payload
//   we, wa, wd             registered write port to the register file
//   b_forced               registered: last grant to B came from the guard
//   conflict_cnt           (only with WB_CONFLICT_COUNT_EN) saturating count
//                          of cycles with both requesters valid
//
// Optional feature macro: WB_CONFLICT_COUNT_EN
module regfile_wb_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ADDRESS_WIDTH-1:0] a_rd,
    input  logic [DATA_WIDTH-1:0]    a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ADDRESS_WIDTH-1:0] b_rd,
    input  logic [DATA_WIDTH-1:0]    b_data,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] wa,
    output logic [DATA_WIDTH-1:0]    wd,
`ifdef WB_CONFLICT_COUNT_EN
    output logic [15:0]              conflict_cnt,
`endif
    output logic                     b_forced
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {
        A_PRI    = 1'b0,
        B_FORCED = 1'b1
    } state_t;

    state_t                   state, next_state;
    logic [CNT_W-1:0]         starve_cnt, starve_cnt_next;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     forced_xfer;

    // Grant, starvation tracking and next write-port values.
    always_comb begin
        next_state      = state;
        starve_cnt_next = starve_cnt;
        a_ready         = 1'b0;
        b_ready         = 1'b0;
        wr_en           = 1'b0;
        wr_addr         = wa;
        wr_data         = wd;
        forced_xfer     = 1'b0;

        if (!rst) begin
            case (state)
                A_PRI: begin
                    a_ready = a_valid;
                    b_ready = b_valid & ~a_valid;
                    if (b_valid && !b_ready) begin
                        starve_cnt_next = starve_cnt + CNT_W'(1);
                    end else begin
                        starve_cnt_next = '0;
                    end
                    if (starve_cnt_next == CNT_W'(STARVE_LIMIT)) begin
                        next_state = B_FORCED;
                    end
                end
                B_FORCED: begin
                    // Forced slot lasts one cycle even if B withdrew.
                    b_ready         = b_valid;
                    a_ready         = a_valid & ~b_valid;
                    forced_xfer     = b_valid;
                    starve_cnt_next = '0;
                    next_state      = A_PRI;
                end
                default: begin
                    next_state      = A_PRI;
                    starve_cnt_next = '0;
                end
            endcase
        end

        // Writes to x0 are accepted but suppressed; wa/wd keep last real write.
        if (a_valid && a_ready && (a_rd != '0)) begin
            wr_en   = 1'b1;
            wr_addr = a_rd;
            wr_data = a_data;
        end else if (b_valid && b_ready && (b_rd != '0)) begin
            wr_en   = 1'b1;
            wr_addr = b_rd;
            wr_data = b_data;
        end
    end

    // State and registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= A_PRI;
            starve_cnt <= '0;
            we         <= 1'b0;
            wa         <= '0;
            wd         <= '0;
            b_forced   <= 1'b0;
        end else begin
            state      <= next_state;
            starve_cnt <= starve_cnt_next;
            we         <= wr_en;
            wa         <= wr_addr;
            wd         <= wr_data;
            b_forced   <= forced_xfer;
        end
    end

`ifdef WB_CONFLICT_COUNT_EN
    // Saturating count of cycles where both requesters contend.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (a_valid && b_valid && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter (default parameters).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_rd, b_rd;
    logic [31:0] a_data, b_data;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        b_forced;
`ifdef WB_CONFLICT_COUNT_EN
    logic [15:0] conflict_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_rd     (a_rd),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_rd     (b_rd),
        .b_data   (b_data),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
`ifdef WB_CONFLICT_COUNT_EN
        .conflict_cnt (conflict_cnt),
`endif
        .b_forced (b_forced)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bdat;
        logic        exp_ar;
        logic        exp_br;
        logic        exp_we;
        logic        chk_wd;
        logic [4:0]  exp_wa;
        logic [31:0] exp_wd;
        logic        exp_bf;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bdat);
        a_valid = av; a_rd = ard; a_data = adat;
        b_valid = bv; b_rd = brd; b_data = bdat;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] DA = 32'hAAAA_0001;
    localparam logic [31:0] DB = 32'hBBBB_0002;

    initial begin
        // av ard adat  bv brd bdat  ar br we chk wa wd bf
        vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            1, 0, 1, 1, 5, 32'hDEADBEEF, 0};
        vecs[1]  = '{0, 0, 0,            0, 0, 0,            0, 0, 0, 1, 5, 32'hDEADBEEF, 0};
        vecs[2]  = '{0, 0, 0,            1, 9, 32'h11111111, 0, 1, 1, 1, 9, 32'h11111111, 0};
        vecs[3]  = '{0, 0, 0,            1, 0, 32'h22222222, 0, 1, 0, 0, 0, 0,            0};
        vecs[4]  = '{1, 0, 32'h3,        0, 0, 0,            1, 0, 0, 0, 0, 0,            0};
        // Continuous contention: 4 A grants then a forced B grant.
        vecs[5]  = '{1, 1, DA, 1, 2, DB, 1, 0, 1, 1, 1, DA, 0};
        vecs[6]  = '{1, 1, DA, 1, 2, DB, 1, 0, 1, 1, 1, DA, 0};
        vecs[7]  = '{1, 1, DA, 1, 2, DB, 1, 0, 1, 1, 1, DA, 0};
        vecs[8]  = '{1, 1, DA, 1, 2, DB, 1, 0, 1, 1, 1, DA, 0};
        vecs[9]  = '{1, 1, DA, 1, 2, DB, 0, 1, 1, 1, 2, DB, 1};
        // Pattern repeats; B withdraws in its forced slot.
        vecs[10] = '{1, 1, DA, 1, 2, DB, 1, 0, 1, 1, 1, DA, 0};
        vecs[11] = '{1, 1, DA, 1, 2, DB, 1, 0, 1, 1, 1, DA, 0};
        vecs[12] = '{1, 1, DA, 1, 2, DB, 1, 0, 1, 1, 1, DA, 0};
        vecs[13] = '{1, 1, DA, 1, 2, DB, 1, 0, 1, 1, 1, DA, 0};
        vecs[14] = '{1, 1, DA, 0, 2, DB, 1, 0, 1, 1, 1, DA, 0};
        // Back in A_PRI with a cleared counter: A wins, then B alone.
        vecs[15] = '{1, 1, DA, 1, 2, DB, 1, 0, 1, 1, 1, DA, 0};
        vecs[16] = '{0, 1, DA, 1, 2, DB, 0, 1, 1, 1, 2, DB, 0};

        // Reset held two cycles with A requesting.
        rst = 1'b1;
        drive(1, 5'd3, 32'h0000_0123, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            chk("rst_a_ready", 32'(a_ready), 32'(1'b0));
            chk("rst_we", 32'(we), 32'(1'b0));
            chk("rst_wa", 32'(wa), 32'(5'd0));
            chk("rst_wd", wd, 32'h0);
            chk("rst_b_forced", 32'(b_forced), 32'(1'b0));
        end
`ifdef WB_CONFLICT_COUNT_EN
        chk("rst_conflict_cnt", 32'(conflict_cnt), 32'h0);
`endif
        rst = 1'b0;
        #1;
        chk("release_a_ready", 32'(a_ready), 32'(1'b1));
        next_cycle();
        chk("release_we", 32'(we), 32'(1'b1));
        chk("release_wa", 32'(wa), 32'(5'd3));
        chk("release_wd", wd, 32'h0000_0123);
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        chk("idle_we", 32'(we), 32'(1'b0));

        // Table of single-cycle vectors.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].bv, vecs[i].brd, vecs[i].bdat);
            #1;
            chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].exp_ar));
            chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].exp_br));
            chk($sformatf("v%0d_one_hot", i), 32'(a_ready & b_ready), 32'(1'b0));
            next_cycle();
            chk($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].exp_we));
            chk($sformatf("v%0d_b_forced", i), 32'(b_forced), 32'(vecs[i].exp_bf));
            if (vecs[i].chk_wd) begin
                chk($sformatf("v%0d_wa", i), 32'(wa), 32'(vecs[i].exp_wa));
                chk($sformatf("v%0d_wd", i), wd, vecs[i].exp_wd);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();

        // Reset in the transfer cycle of rd 7: grant dropped, no write.
        drive(1, 5'd7, 32'h7777_7777, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_a_ready", 32'(a_ready), 32'(1'b0));
        next_cycle();
        chk("midrst_we", 32'(we), 32'(1'b0));
        chk("midrst_wa", 32'(wa), 32'(5'd0));
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        chk("midrst_after_we", 32'(we), 32'(1'b0));

`ifdef WB_CONFLICT_COUNT_EN
        // Reset clears the counter; three contention cycles count three.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        chk("cc_after_rst", 32'(conflict_cnt), 32'h0);
        drive(1, 1, DA, 1, 2, DB);
        for (int i = 0; i < 3; i++) next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        chk("cc_three", 32'(conflict_cnt), 32'd3);
        next_cycle();
        chk("cc_hold", 32'(conflict_cnt), 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
